// File: rtl/bc_pkg.sv
// Shared basic-computer constants: sequence-count width
// and named timing indices for T decoding.
package bc_pkg;

  localparam int SC_WIDTH = 4;
  localparam int T_WIDTH  = 2 ** SC_WIDTH;

  localparam int T0  = 0;
  localparam int T1  = 1;
  localparam int T2  = 2;
  localparam int T3  = 3;
  localparam int T4  = 4;
  localparam int T5  = 5;
  localparam int T6  = 6;
  localparam int T7  = 7;
  localparam int T8  = 8;
  localparam int T9  = 9;
  localparam int T10 = 10;
  localparam int T11 = 11;
  localparam int T12 = 12;
  localparam int T13 = 13;
  localparam int T14 = 14;
  localparam int T15 = 15;

endpackage

// File: rtl/decoder_n2onehot.sv
// Binary to one-hot decoder, N select bits to 2**N lines.
// Also serves the controller's 3-to-8 opcode decode.
module decoder_n2onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0]      sel,
  output logic [2**N-1:0]   onehot
);

  localparam int M = 2 ** N;

  assign onehot = M'(1) << sel;

endmodule

// File: rtl/sequence_counter.sv
// Sequence counter for the control unit: count register
// with clear/increment priority, decoded to one-hot T.
module sequence_counter
  import bc_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                CLR,
  input  logic                INR,
  output logic [2**WIDTH-1:0] T,
  output logic [WIDTH-1:0]    SC
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear outranks increment; increment wraps naturally.
  always_comb begin
    count_d = count_q;
    if (CLR) begin
      count_d = '0;
    end else if (INR) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  decoder_n2onehot #(
    .N (WIDTH)
  ) u_dec (
    .sel    (count_q),
    .onehot (T)
  );

  assign SC = count_q;

endmodule

// File: tb/tb_sequence_counter.sv
// Scoreboard bench for sequence_counter: driver queues
// expected T/SC, monitor pops and compares on each sample.
module tb_sequence_counter;

  logic        clk;
  logic        rst_n;
  logic        CLR;
  logic        INR;
  logic [15:0] T;
  logic [3:0]  SC;

  typedef struct {
    string       name;
    logic [15:0] t;
    logic [3:0]  sc;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   n_vec;
  int   n_bad;

  sequence_counter #(
    .WIDTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .CLR   (CLR),
    .INR   (INR),
    .T     (T),
    .SC    (SC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_now(input string nm,
                            input logic [15:0] et,
                            input logic [3:0] esc);
    exp_t e;
    e.name = nm;
    e.t    = et;
    e.sc   = esc;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  task automatic step(input string nm,
                      input logic c,
                      input logic i,
                      input logic [3:0] esc,
                      input logic [15:0] et);
    @(negedge clk);
    CLR = c;
    INR = i;
    @(posedge clk);
    #1;
    expect_now(nm, et, esc);
  endtask

  // Monitor: drains the scoreboard whenever a sample is flagged.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (T !== e.t || SC !== e.sc || !$onehot(T)) begin
          n_bad++;
          $display("FAIL %s: T=%h SC=%0d, want T=%h SC=%0d",
                   e.name, T, SC, e.t, e.sc);
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b1;
    CLR   = 1'b0;
    INR   = 1'b0;

    #2 rst_n = 1'b0;
    #1 expect_now("reset_async", 16'h0001, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++)
      step("reset_hold", 1'b0, 1'b0, 4'd0, 16'h0001);

    step("inr1", 1'b0, 1'b1, 4'd1, 16'h0002);
    step("inr2", 1'b0, 1'b1, 4'd2, 16'h0004);
    step("inr3", 1'b0, 1'b1, 4'd3, 16'h0008);
    step("clr_from3", 1'b1, 1'b0, 4'd0, 16'h0001);

    for (int k = 1; k <= 16; k++)
      step("wrap", 1'b0, 1'b1, 4'(k % 16),
           16'h0001 << (k % 16));
    step("wrap_end15", 1'b0, 1'b0, 4'd0, 16'h0001);

    for (int k = 1; k <= 5; k++)
      step("to5a", 1'b0, 1'b1, 4'(k), 16'h0001 << k);
    step("clr_alone", 1'b1, 1'b0, 4'd0, 16'h0001);
    for (int k = 1; k <= 5; k++)
      step("to5b", 1'b0, 1'b1, 4'(k), 16'h0001 << k);
    step("clr_and_inr", 1'b1, 1'b1, 4'd0, 16'h0001);

    for (int k = 1; k <= 7; k++)
      step("to7", 1'b0, 1'b1, 4'(k), 16'h0001 << k);
    expect_now("at7", 16'h0080, 4'd7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 expect_now("reset_mid", 16'h0001, 4'd0);
    CLR = 1'b0;
    INR = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 expect_now("reset_ign_inr", 16'h0001, 4'd0);
    end
    @(negedge clk);
    INR   = 1'b0;
    rst_n = 1'b1;
    step("post_release", 1'b0, 1'b0, 4'd0, 16'h0001);

    for (int k = 1; k <= 9; k++)
      step("to9", 1'b0, 1'b1, 4'(k), 16'h0001 << k);
    for (int k = 0; k < 4; k++)
      step("hold9", 1'b0, 1'b0, 4'd9, 16'h0200);
    step("inr_after_hold", 1'b0, 1'b1, 4'd10, 16'h0400);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
